// File: rtl/addsub_seq.sv
// Slice-serial WIDTH-bit add/subtract with carry, overflow, zero, negative flags.
// Define ADDSUB_SATURATE_EN to clamp overflowing results to the signed limit.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             OverFlow,
  output logic             ZeroFlag,
  output logic             NegFlag
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] full;
  logic [WIDTH-1:0] fin;
  logic             mode_q;
  logic             carry;
  logic [SLICE:0]   sum;
  logic             ovf;

  // b_q already holds ~B for subtraction, so one overflow rule covers both
  always_comb begin
    sum = {1'b0, a_q[idx*SLICE +: SLICE]}
        + {1'b0, b_q[idx*SLICE +: SLICE]}
        + {{SLICE{1'b0}}, carry};
    full = part;
    full[idx*SLICE +: SLICE] = sum[SLICE-1:0];
    ovf = (a_q[WIDTH-1] == b_q[WIDTH-1])
       && (full[WIDTH-1] != a_q[WIDTH-1]);
  end

`ifdef ADDSUB_SATURATE_EN
  always_comb begin
    fin = full;
    if (ovf) begin
      fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign fin = full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part     <= '0;
      mode_q   <= 1'b0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      Cout     <= 1'b0;
      OverFlow <= 1'b0;
      ZeroFlag <= 1'b0;
      NegFlag  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= mode ? ~B : B;
            mode_q <= mode;
            carry  <= mode;
            part   <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          part  <= full;
          carry <= sum[SLICE];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            result   <= fin;
            Cout     <= sum[SLICE] ^ mode_q;
            OverFlow <= ovf;
            ZeroFlag <= (fin == '0);
            NegFlag  <= fin[WIDTH-1];
            busy     <= 1'b0;
            done     <= 1'b1;
            idx      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed table, hand sequences, random ops vs model.
module tb_addsub_seq;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         Cout;
  logic         OverFlow;
  logic         ZeroFlag;
  logic         NegFlag;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] prev_r;

  addsub_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .A(A), .B(B), .busy(busy), .done(done), .result(result),
    .Cout(Cout), .OverFlow(OverFlow), .ZeroFlag(ZeroFlag),
    .NegFlag(NegFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic m, input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c,
                                output logic v, output logic z,
                                output logic n);
    int sa, sb, t;
    int ua, ub, ut;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (m) begin
      ut = ua - ub;
      t  = sa - sb;
      c  = (ua < ub);
    end else begin
      ut = ua + ub;
      t  = sa + sb;
      c  = (ut >= 65536);
    end
    r = ut[W-1:0];
    v = (t > 32767) || (t < -32768);
`ifdef ADDSUB_SATURATE_EN
    if (v) r = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    z = (r == '0);
    n = r[W-1];
  endfunction

  // Issues one op; inj > 0 pulses a junk start on that RUN cycle.
  task automatic run_op(input string tag, input logic m,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj);
    logic [W-1:0] er;
    logic ec, ev, ez, en;
    int lat;
    int busy_cnt;
    model(m, a, b, er, ec, ev, ez, en);
    @(negedge clk);
    mode = m; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b; mode = ~m;
    chk({tag, "_busy_up"}, 32'(busy), 1);
    chk({tag, "_held"}, 32'(result), 32'(prev_r));
    lat = 0;
    busy_cnt = 1;
    for (int k = 1; k <= N + 2; k++) begin
      if (k == inj) begin
        start = 1'b1; A = 16'h5A5A; B = 16'h1357; mode = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      busy_cnt += busy ? 1 : 0;
    end
    chk({tag, "_latency"}, 32'(lat), N);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), N);
    chk({tag, "_busy_low"}, 32'(busy), 0);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_flags"}, {28'd0, Cout, OverFlow, ZeroFlag, NegFlag},
        {28'd0, ec, ev, ez, en});
    prev_r = er;
  endtask

  vec_t tbl[6];

  initial begin
    logic [W-1:0] ra, rb;
    logic rm;
    logic [W-1:0] sat_r;
    logic sat_n;
`ifdef ADDSUB_SATURATE_EN
    sat_r = 16'h7FFF; sat_n = 1'b0;
`else
    sat_r = 16'h8000; sat_n = 1'b1;
`endif
    tbl[0] = '{1'b0, 16'h1234, 16'h0FF0, 16'h2224, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1, 0, 0, 1};
    tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, sat_r, 0, 1, 0, sat_n};
    tbl[3] = '{1'b1, 16'hABCD, 16'hABCD, 16'h0000, 0, 0, 1, 0};
    tbl[4] = '{1'b0, 16'h00F8, 16'h0008, 16'h0100, 0, 0, 0, 0};
    tbl[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 0};
`ifdef ADDSUB_SATURATE_EN
    tbl[5].r = 16'h8000; tbl[5].n = 1'b1;
`endif
    prev_r = '0;

    #12;
    chk("reset_outs", {25'd0, busy, done, Cout, OverFlow, ZeroFlag,
                       NegFlag, 1'b0}, 0);
    chk("reset_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: fixed expectations, run back to back
    foreach (tbl[i]) begin
      run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].a, tbl[i].b, 0);
      chk($sformatf("tbl%0d_r", i), 32'(result), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_f", i),
          {28'd0, Cout, OverFlow, ZeroFlag, NegFlag},
          {28'd0, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_pulse", i), 32'(done), 0);
    end

    // Mid-RUN start must be ignored
    run_op("ignore", 1'b0, 16'hFFFF, 16'h0001, 2);
    chk("ignore_r", 32'(result), 0);
    chk("ignore_cz", {30'd0, Cout, ZeroFlag}, 3);
    @(posedge clk); #1;
    chk("ignore_no_second", 32'(busy | done), 0);

    // Reset aborts an op in flight
    @(negedge clk);
    mode = 1'b0; A = 16'h1111; B = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {25'd0, busy, done, Cout, OverFlow, ZeroFlag,
                       NegFlag, 1'b0}, 0);
    chk("abort_result", 32'(result), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_idle", 32'(busy | done), 0);
    end
    prev_r = '0;
    run_op("after_rst", 1'b0, 16'h0001, 16'h0001, 0);
    chk("after_rst_r", 32'(result), 2);

    // Random ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = 16'h7FFF ^ 16'($urandom_range(0, 3));
      if (i % 8 == 2) ra = 16'h8000 | 16'($urandom_range(0, 3));
      run_op($sformatf("rnd%0d", i), rm, ra, rb, (i % 5 == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
